md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; successor to the fixed 32-bit mult module in the execute stage.
- The execute stage issues an operation with a start pulse and stalls on busy.
- HI/LO feed the ALU/mult result mux for MFHI/MFLO.
- Adds configurable width and latencies, a flush-cancel input, defined divide corner cases, a done pulse and optional accumulate ops.

Parameters:
WIDTH, 32, operand and HI/LO width; must be >=8.
MULT_LAT, 5, cycles busy for MULT/MULTU/MADD/MSUB; must be >=1.
DIV_LAT, 10, cycles busy for DIV/DIVU; must be >=1.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  issue strobe; sampled on each rising edge.
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
a  in  WIDTH  forwarded rs operand.
b  in  WIDTH  forwarded rt operand.
flush  in  1  cancel the in-flight operation (exception/branch kill).
busy  out  1  operation in progress; upstream stalls mult/div/mfhi/mflo/mthi/mtlo while high.
done  out  1  one-cycle pulse on the edge where a mult/div result is written.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - hi=0, lo=0, busy=0, done=0.
  - Cycle counter cleared; latched operands discarded.
- Acceptance:
  - start is accepted only on an edge where busy=0 and flush=0.
  - start while busy=1 is ignored entirely; it causes no state change and no queueing.
- Mult/div ops:
  - On acceptance, a, b and op are latched.
  - busy=1 from the next cycle for exactly LAT cycles (MULT_LAT or DIV_LAT).
  - On the LAT-th edge after the accepting edge:
    - hi/lo are written.
    - busy falls.
    - done=1 for that one cycle.
  - Back-to-back: a new start may be accepted on the first edge with busy=0.
- MTHI/MTLO:
  - On acceptance, hi (or lo) := a at that same edge.
  - busy stays 0 and done stays 0.
  - The other register is unchanged.
- State machine: IDLE -> (accepted mult/div) RUN -> (counter==LAT-1) IDLE with write.
  - flush in RUN -> IDLE at the next edge; hi/lo keep pre-op values; no done.
  - flush in IDLE has no effect and blocks acceptance of a start on the same edge.
- Arithmetic:
  - MULT: signed WIDTH x WIDTH -> 2*WIDTH product; {hi,lo} = product.
  - MULTU: the same, unsigned.
  - DIV: signed, quotient truncated toward zero; lo=quotient; hi=remainder, with the sign of the dividend.
  - DIVU: unsigned; lo=quotient, hi=remainder.
- Divide by zero (both DIV and DIVU): lo = all ones; hi = a.
- Signed overflow, DIV of most-negative by -1: lo = most-negative; hi = 0.
- Operand stability: results depend only on the latched operands; a/b may change freely while busy.
- Ops 110/111 without the optional feature: treated as no-op; not accepted, busy stays 0.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined:
  - MADD: {hi,lo} := {hi,lo} + signed(a)*signed(b), modulo 2^(2*WIDTH).
  - MSUB: {hi,lo} := {hi,lo} - signed(a)*signed(b), modulo 2^(2*WIDTH).
  - The accumulator value is the {hi,lo} present at the write edge.
  - Both use MULT_LAT timing, done and flush exactly like MULT.
- When not defined:
  - op 110/111 ignored as no-ops.
  - No accumulate datapath is synthesised.

Test Plan:
1. Reset, then MULT a=0xFFFFFFFF b=0x00000002:
   - busy high 5 cycles; done pulses once.
   - Result hi=0xFFFFFFFF lo=0xFFFFFFFE.
   - MULTU with the same operands gives hi=0x00000001 lo=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7) b=0x00000002:
   - busy high 10 cycles.
   - Result lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100/7 gives lo=14, hi=2.
3. Divide corner cases:
   - DIVU a=0x1234 b=0: lo=0xFFFFFFFF hi=0x1234.
   - DIV a=0x80000000 b=0xFFFFFFFF: lo=0x80000000 hi=0.
4. Ignored start and flush:
   - Start MULT, then assert start with DIV on busy cycle 2: ignored, and MULT completes at cycle 5.
   - Start DIV, then flush on busy cycle 3: busy=0 next cycle, hi/lo unchanged, no done.
5. MTHI and reset:
   - MTHI a=0xDEADBEEF: hi=0xDEADBEEF after one edge; busy never rises; lo unchanged.
   - Assert reset during MULT busy cycle 2: hi=lo=0, busy=0 immediately.
6. MADD with MD_MADD_EN defined:
   - Start from hi=0, lo=0xFFFFFFFF; MADD a=1 b=1 gives hi=0x00000001 lo=0x00000000.
   - MSUB a=1 b=1 then returns to hi=0 lo=0xFFFFFFFF.
   - Without the macro, op 110 leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/md_unit_if.sv
// Issue/result bundle between the execute stage and md_unit.
// The execute stage drives the master side; md_unit is the slave.
interface md_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MD_MADD_EN to add MADD/MSUB accumulate ops; otherwise ops 110/111 are no-ops.
module md_unit #(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave bus
);
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MD_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;
`endif
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [0:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
   logic             r_done;

   logic                    w_idle_ok, w_md_op, w_is_div, w_last;
   logic [CW-1:0]           w_lat_m1;
   logic [2*WIDTH-1:0]      w_sprod, w_uprod;
   logic signed [WIDTH-1:0] w_sa, w_sb;
   logic [WIDTH-1:0]        w_res_hi, w_res_lo;

   assign w_idle_ok = (r_state == S_IDLE) && bus.start && !bus.flush;
   assign w_is_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);
   assign w_lat_m1  = w_is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
   assign w_last    = (r_cnt == w_lat_m1);

   assign w_sa = r_a;
   assign w_sb = r_b;
   // Low 2*WIDTH bits of the widened product are exact for both signednesses.
   assign w_sprod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
   assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

   always_comb begin
      w_md_op = 1'b0;
      case (bus.op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_md_op = 1'b1;
`ifdef MD_MADD_EN
         OP_MADD, OP_MSUB:                   w_md_op = 1'b1;
`endif
         default:                            w_md_op = 1'b0;
      endcase
   end

   always_comb begin
      w_res_hi = r_hi;
      w_res_lo = r_lo;
      case (r_op)
         OP_MULT:  {w_res_hi, w_res_lo} = w_sprod;
         OP_MULTU: {w_res_hi, w_res_lo} = w_uprod;
         OP_DIV: begin
            if (r_b == '0) begin
               w_res_lo = '1;
               w_res_hi = r_a;
            end else if (r_a == MOST_NEG && r_b == '1) begin
               w_res_lo = MOST_NEG;
               w_res_hi = '0;
            end else begin
               w_res_lo = w_sa / w_sb;
               w_res_hi = w_sa % w_sb;
            end
         end
         OP_DIVU: begin
            if (r_b == '0) begin
               w_res_lo = '1;
               w_res_hi = r_a;
            end else begin
               w_res_lo = r_a / r_b;
               w_res_hi = r_a % r_b;
            end
         end
`ifdef MD_MADD_EN
         // Accumulate against HI/LO as they stand at the write edge.
         OP_MADD: {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_sprod;
         OP_MSUB: {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_sprod;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_idle_ok && w_md_op) begin
                  r_op    <= bus.op;
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end else if (w_idle_ok && bus.op == OP_MTHI) begin
                  r_hi <= bus.a;
               end else if (w_idle_ok && bus.op == OP_MTLO) begin
                  r_lo <= bus.a;
               end
            end
            default: begin
               if (bus.flush) begin
                  r_state <= S_IDLE;
               end else if (w_last) begin
                  r_hi    <= w_res_hi;
                  r_lo    <= w_res_lo;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.busy = (r_state == S_RUN);
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit at default parameters (WIDTH=32, MULT_LAT=5, DIV_LAT=10).
// Covers both builds: the accumulate test follows MD_MADD_EN.
module tb_md_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;

   md_unit_if #(.WIDTH(32)) bus ();
   md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one start for a single edge, then sample each cycle until busy falls.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int nb, output int nd);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
      @(negedge clk);
      bus.start = 1'b0;
      nb = 0; nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) nb++;
         if (bus.done) nd++;
         if (!bus.busy) break;
         @(negedge clk);
      end
      @(negedge clk);
      if (bus.done) nd++;
   endtask

   task automatic write_reg(input logic [2:0] o, input logic [31:0] x);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = 32'h0;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #1;
      checks += 4;
      if (bus.hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
      if (bus.lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mult;
      int nb, nd;
      run_op(3'b000, 32'hFFFFFFFF, 32'h2, nb, nd);
      checks += 4;
      if (nb !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", nb); end
      if (nd !== 1) begin failures++; $display("FAIL mult_done_pulses got=%0d exp=1", nd); end
      if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi); end
      if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", bus.lo); end
      run_op(3'b001, 32'hFFFFFFFF, 32'h2, nb, nd);
      checks += 2;
      if (bus.hi !== 32'h1)        begin failures++; $display("FAIL multu_hi got=%h exp=00000001", bus.hi); end
      if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", bus.lo); end
   endtask

   task automatic test_div;
      int nb, nd;
      run_op(3'b010, 32'hFFFFFFF9, 32'h2, nb, nd);
      checks += 4;
      if (nb !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", nb); end
      if (nd !== 1)  begin failures++; $display("FAIL div_done_pulses got=%0d exp=1", nd); end
      if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo); end
      if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi); end
      run_op(3'b011, 32'd100, 32'd7, nb, nd);
      checks += 2;
      if (bus.lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%0d exp=14", bus.lo); end
      if (bus.hi !== 32'd2)  begin failures++; $display("FAIL divu_hi got=%0d exp=2", bus.hi); end
      run_op(3'b010, 32'd7, 32'hFFFFFFFE, nb, nd);
      checks += 2;
      if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdivisor_lo got=%h exp=fffffffd", bus.lo); end
      if (bus.hi !== 32'h1)        begin failures++; $display("FAIL div_negdivisor_hi got=%h exp=00000001", bus.hi); end
   endtask

   task automatic test_div_corner;
      int nb, nd;
      run_op(3'b011, 32'h1234, 32'h0, nb, nd);
      checks += 2;
      if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", bus.lo); end
      if (bus.hi !== 32'h1234)     begin failures++; $display("FAIL divu_zero_hi got=%h exp=00001234", bus.hi); end
      run_op(3'b010, 32'hFFFFFFFB, 32'h0, nb, nd);
      checks += 2;
      if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_zero_lo got=%h exp=ffffffff", bus.lo); end
      if (bus.hi !== 32'hFFFFFFFB) begin failures++; $display("FAIL div_zero_hi got=%h exp=fffffffb", bus.hi); end
      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, nb, nd);
      checks += 2;
      if (bus.lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", bus.lo); end
      if (bus.hi !== 32'h0)        begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", bus.hi); end
   endtask

   task automatic test_ignored_start;
      int nb, nd;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd4;
      @(negedge clk);                       // busy cycle 1
      bus.start = 1'b0;
      @(negedge clk);                       // busy cycle 2
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
      @(negedge clk);                       // busy cycle 3
      bus.start = 1'b0;
      nb = 2; nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy) nb++;
         if (bus.done) nd++;
         if (!bus.busy) break;
         @(negedge clk);
      end
      @(negedge clk);
      if (bus.done) nd++;
      checks += 5;
      if (nb !== 5)          begin failures++; $display("FAIL ign_busy_cycles got=%0d exp=5", nb); end
      if (nd !== 1)          begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", nd); end
      if (bus.lo !== 32'd12) begin failures++; $display("FAIL ign_lo got=%0d exp=12", bus.lo); end
      if (bus.hi !== 32'd0)  begin failures++; $display("FAIL ign_hi got=%0d exp=0", bus.hi); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL ign_no_queue got=%b exp=0", bus.busy); end
   endtask

   task automatic test_back_to_back;
      int nb, nd;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd2; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b001; bus.a = 32'd5; bus.b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      checks += 2;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
      if (bus.lo !== 32'd6)  begin failures++; $display("FAIL b2b_first_lo got=%0d exp=6", bus.lo); end
      nb = 0;
      for (int i = 0; i < 40 && bus.busy; i++) begin nb++; @(negedge clk); end
      checks += 2;
      if (nb !== 5)          begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=5", nb); end
      if (bus.lo !== 32'd25) begin failures++; $display("FAIL b2b_second_lo got=%0d exp=25", bus.lo); end
   endtask

   task automatic test_flush;
      int nd;
      write_reg(3'b100, 32'h11);
      write_reg(3'b101, 32'h22);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b010; bus.a = 32'd100; bus.b = 32'd7;
      @(negedge clk);                       // busy cycle 1
      bus.start = 1'b0;
      @(negedge clk);                       // busy cycle 2
      @(negedge clk);                       // busy cycle 3
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      checks += 3;
      if (bus.busy !== 1'b0)  begin failures++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
      if (bus.hi !== 32'h11)  begin failures++; $display("FAIL flush_hi got=%h exp=11", bus.hi); end
      if (bus.lo !== 32'h22)  begin failures++; $display("FAIL flush_lo got=%h exp=22", bus.lo); end
      nd = 0;
      for (int i = 0; i < 12; i++) begin if (bus.done) nd++; @(negedge clk); end
      checks++;
      if (nd !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", nd); end
      // Flush while idle must block a same-edge start.
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b100; bus.a = 32'h99;
      @(negedge clk);
      bus.op = 3'b000; bus.a = 32'd3; bus.b = 32'd3;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      checks += 2;
      if (bus.hi !== 32'h11) begin failures++; $display("FAIL flush_idle_mthi got=%h exp=11", bus.hi); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_idle_mult got=%b exp=0", bus.busy); end
   endtask

   task automatic test_mthi;
      write_reg(3'b101, 32'h5A5A);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEADBEEF;
      @(negedge clk);
      bus.start = 1'b0;
      checks += 4;
      if (bus.hi !== 32'hDEADBEEF) begin failures++; $display("FAIL mthi_hi got=%h exp=deadbeef", bus.hi); end
      if (bus.lo !== 32'h5A5A)     begin failures++; $display("FAIL mthi_lo got=%h exp=5a5a", bus.lo); end
      if (bus.busy !== 1'b0)       begin failures++; $display("FAIL mthi_busy got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0)       begin failures++; $display("FAIL mthi_done got=%b exp=0", bus.done); end
      write_reg(3'b101, 32'hCAFE);
      checks += 2;
      if (bus.lo !== 32'hCAFE)     begin failures++; $display("FAIL mtlo_lo got=%h exp=cafe", bus.lo); end
      if (bus.hi !== 32'hDEADBEEF) begin failures++; $display("FAIL mtlo_hi got=%h exp=deadbeef", bus.hi); end
   endtask

   task automatic test_reset_mid;
      int nb, nd;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd7; bus.b = 32'd9;
      @(negedge clk);                       // busy cycle 1
      bus.start = 1'b0;
      @(negedge clk);                       // busy cycle 2
      reset = 1'b1;
      #1;
      checks += 3;
      if (bus.hi !== 32'h0)  begin failures++; $display("FAIL rstmid_hi got=%h exp=0", bus.hi); end
      if (bus.lo !== 32'h0)  begin failures++; $display("FAIL rstmid_lo got=%h exp=0", bus.lo); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      @(negedge clk);
      reset = 1'b0;
      run_op(3'b001, 32'd3, 32'd3, nb, nd);
      checks += 2;
      if (nb !== 5)         begin failures++; $display("FAIL rstmid_after_busy got=%0d exp=5", nb); end
      if (bus.lo !== 32'd9) begin failures++; $display("FAIL rstmid_after_lo got=%0d exp=9", bus.lo); end
   endtask

   task automatic test_madd;
      int nb, nd;
      write_reg(3'b100, 32'h0);
      write_reg(3'b101, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
      run_op(3'b110, 32'd1, 32'd1, nb, nd);
      checks += 4;
      if (nb !== 5)         begin failures++; $display("FAIL madd_busy got=%0d exp=5", nb); end
      if (nd !== 1)         begin failures++; $display("FAIL madd_done got=%0d exp=1", nd); end
      if (bus.hi !== 32'h1) begin failures++; $display("FAIL madd_hi got=%h exp=1", bus.hi); end
      if (bus.lo !== 32'h0) begin failures++; $display("FAIL madd_lo got=%h exp=0", bus.lo); end
      run_op(3'b111, 32'd1, 32'd1, nb, nd);
      checks += 2;
      if (bus.hi !== 32'h0)        begin failures++; $display("FAIL msub_hi got=%h exp=0", bus.hi); end
      if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL msub_lo got=%h exp=ffffffff", bus.lo); end
      run_op(3'b110, 32'hFFFFFFFF, 32'd1, nb, nd);
      checks += 2;
      if (bus.hi !== 32'h0)        begin failures++; $display("FAIL madd_neg_hi got=%h exp=0", bus.hi); end
      if (bus.lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL madd_neg_lo got=%h exp=fffffffe", bus.lo); end
`else
      run_op(3'b110, 32'd1, 32'd1, nb, nd);
      checks += 3;
      if (nb !== 0)                begin failures++; $display("FAIL madd_off_busy got=%0d exp=0", nb); end
      if (bus.hi !== 32'h0)        begin failures++; $display("FAIL madd_off_hi got=%h exp=0", bus.hi); end
      if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL madd_off_lo got=%h exp=ffffffff", bus.lo); end
      run_op(3'b111, 32'd1, 32'd1, nb, nd);
      checks += 2;
      if (nb !== 0)                begin failures++; $display("FAIL msub_off_busy got=%0d exp=0", nb); end
      if (bus.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL msub_off_lo got=%h exp=ffffffff", bus.lo); end
`endif
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'b000; bus.a = 32'h0; bus.b = 32'h0; bus.flush = 1'b0;
      test_reset();
      test_mult();
      test_div();
      test_div_corner();
      test_ignored_start();
      test_back_to_back();
      test_flush();
      test_mthi();
      test_reset_mid();
      test_madd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
